// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - pc_state_e  : sequencer state encoding (BOOT / RUN / HALTED; 3 is illegal)
//   - ALIGN_MASK  : low address bits that must be zero for a legal fetch target
//   - BOOT_CNT_W  : width of the boot-delay counter
//   - is_misaligned(): true when an address violates ALIGN_MASK
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         BOOT_CNT_W = 8;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_adder.sv
// pc_adder: sequential-path incrementer for the fetch address.
//   pc       in  32  current program counter
//   pc_plus4 out 32  pc + 4, wrapping modulo 2^32
module pc_adder (
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC register of the single-cycle CPU, chooses the next
// fetch address (sequential / branch / jump / trap vector) and sequences the
// boot delay, stall, and halt/resume behaviour.
//   clk           in   1  rising-edge clock
//   rst           in   1  asynchronous active-high reset
//   stall         in   1  freeze PC, state and counters while in RUN
//   branch_taken  in   1  redirect to branch_target
//   branch_target in  32  branch destination
//   jump          in   1  redirect to jump_target (beats branch_taken)
//   jump_target   in  32  jump destination
//   halt          in   1  current instruction is a halt (beats jump/branch)
//   resume        in   1  leave HALTED, continue at PC + 4
//   pc            out 32  current fetch address (registered)
//   pc_plus4      out 32  pc + 4 (combinational)
//   fetch_en      out  1  instruction-memory read enable
//   misalign      out  1  pulse while PC first shows the trap vector
//   state         out  2  0=BOOT, 1=RUN, 2=HALTED
//   retired       out 32  retired-instruction count (wraps)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_en,
    output logic        misalign,
    output logic [1:0]  state,
    output logic [31:0] retired
);

    localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES);

    pc_state_e             state_reg, state_next;
    logic [31:0]           pc_reg, pc_next;
    logic [BOOT_CNT_W-1:0] boot_cnt_reg, boot_cnt_next;
    logic [31:0]           retired_reg, retired_next;
    logic                  misalign_reg, misalign_next;
    logic [31:0]           candidate;
    logic                  redirect;

    pc_adder u_pc_adder (
        .pc       (pc_reg),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            boot_cnt_reg <= '0;
            retired_reg  <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            boot_cnt_reg <= boot_cnt_next;
            retired_reg  <= retired_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        boot_cnt_next = boot_cnt_reg;
        retired_next  = retired_reg;
        misalign_next = 1'b0;
        redirect      = jump | branch_taken;
        candidate     = jump ? jump_target : (branch_taken ? branch_target : pc_plus4);

        case (state_reg)
            ST_BOOT: begin
                // Inputs are ignored until the boot delay has elapsed.
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    // Every non-stalled cycle retires one instruction,
                    // including the halt itself and trapped redirects.
                    retired_next = retired_reg + 32'd1;
                    if (halt) begin
                        state_next = ST_HALTED;
                    end else if (redirect && is_misaligned(candidate)) begin
                        pc_next       = TRAP_VECTOR;
                        misalign_next = 1'b1;
                    end else begin
                        pc_next = candidate;
                    end
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    pc_next    = pc_plus4;
                    state_next = ST_RUN;
                end
            end
            default: begin
                // Unreachable encoding: restart the boot sequence.
                state_next    = ST_BOOT;
                boot_cnt_next = '0;
            end
        endcase
    end

    assign fetch_en = (state_reg == ST_RUN) && !stall;
    assign pc       = pc_reg;
    assign misalign = misalign_reg;
    assign state    = state_reg;
    assign retired  = retired_reg;

endmodule
